// File: rtl/pipe_ctl_pkg.sv
// Shared pipeline definitions: NOP encoding, hazard vector bit positions and
// the per-cycle action selected by the pipeline controller.
package pipe_ctl_pkg;

  localparam logic [6:0]  OP_OPIMM = 7'b0010011;
  localparam logic [2:0]  F3_ADDI  = 3'b000;
  // addi x0,x0,0
  localparam logic [31:0] NOP      = {12'h000, 5'd0, F3_ADDI, 5'd0, OP_OPIMM};

  localparam int unsigned HZ_D = 3;
  localparam int unsigned HZ_X = 2;
  localparam int unsigned HZ_M = 1;
  localparam int unsigned HZ_W = 0;

  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_FREEZE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_STALL  = 2'd3
  } act_e;

  // Priority: freeze > flush > load-use stall > advance (reset handled by caller).
  function automatic act_e pick_act(input logic busy, input logic br, input logic hz_x);
    act_e res;
    if (busy) begin
      res = ACT_FREEZE;
    end else if (br) begin
      res = ACT_FLUSH;
    end else if (hz_x) begin
      res = ACT_STALL;
    end else begin
      res = ACT_NORMAL;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctl_sat_cnt16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF.
module sat_cnt16 (
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // Clear wins; otherwise count up until all ones, then hold.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= 16'h0000;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctl.sv
// Five-stage pipeline controller: stage instruction/PC/valid registers with
// freeze, branch flush and load-use bubble handling, plus event counters.
module pipe_ctl
  import pipe_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_f,
  input  logic [31:0] pc_f,
  input  logic [3:0]  d_x_m_w,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic [31:0] inst_d,
  output logic [31:0] inst_x,
  output logic [31:0] inst_m,
  output logic [31:0] inst_w,
  output logic [31:0] pc_d,
  output logic [31:0] pc_x,
  output logic        vld_d,
  output logic        vld_x,
  output logic        vld_m,
  output logic        vld_w,
  output logic        pc_en,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [31:0] r_inst_d, r_inst_x, r_inst_m, r_inst_w;
  logic [31:0] r_pc_d, r_pc_x;
  logic        r_vld_d, r_vld_x, r_vld_m, r_vld_w;
  act_e        w_act;
  logic        w_stall_en;
  logic        w_flush_en;
  logic        w_unused_rsvd;

  always_comb begin
    w_act      = pick_act(mem_busy, br_taken, d_x_m_w[HZ_X]);
    w_stall_en = 1'b0;
    w_flush_en = 1'b0;
    if (!rst) begin
      w_stall_en = (w_act == ACT_STALL);
      w_flush_en = (w_act == ACT_FLUSH);
    end else begin
      w_stall_en = 1'b0;
      w_flush_en = 1'b0;
    end
  end

  // Reserved hazard bits carry no meaning for this controller.
  assign w_unused_rsvd = ^{d_x_m_w[HZ_D], d_x_m_w[HZ_M], d_x_m_w[HZ_W]};

  assign pc_en = !rst && !mem_busy && (br_taken || !d_x_m_w[HZ_X]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_d <= NOP;
      r_inst_x <= NOP;
      r_inst_m <= NOP;
      r_inst_w <= NOP;
      r_pc_d   <= 32'h0000_0000;
      r_pc_x   <= 32'h0000_0000;
      r_vld_d  <= 1'b0;
      r_vld_x  <= 1'b0;
      r_vld_m  <= 1'b0;
      r_vld_w  <= 1'b0;
    end else begin
      case (w_act)
        ACT_FREEZE: begin
          r_inst_d <= r_inst_d;
          r_inst_x <= r_inst_x;
          r_inst_m <= r_inst_m;
          r_inst_w <= r_inst_w;
          r_pc_d   <= r_pc_d;
          r_pc_x   <= r_pc_x;
          r_vld_d  <= r_vld_d;
          r_vld_x  <= r_vld_x;
          r_vld_m  <= r_vld_m;
          r_vld_w  <= r_vld_w;
        end
        ACT_FLUSH: begin
          // Wrong-path instructions in D and X are squashed; X still retires forward.
          r_inst_d <= NOP;
          r_inst_x <= NOP;
          r_inst_m <= r_inst_x;
          r_inst_w <= r_inst_m;
          r_pc_d   <= 32'h0000_0000;
          r_pc_x   <= 32'h0000_0000;
          r_vld_d  <= 1'b0;
          r_vld_x  <= 1'b0;
          r_vld_m  <= r_vld_x;
          r_vld_w  <= r_vld_m;
        end
        ACT_STALL: begin
          r_inst_d <= r_inst_d;
          r_inst_x <= NOP;
          r_inst_m <= r_inst_x;
          r_inst_w <= r_inst_m;
          r_pc_d   <= r_pc_d;
          r_pc_x   <= 32'h0000_0000;
          r_vld_d  <= r_vld_d;
          r_vld_x  <= 1'b0;
          r_vld_m  <= r_vld_x;
          r_vld_w  <= r_vld_m;
        end
        ACT_NORMAL: begin
          r_inst_d <= inst_f;
          r_inst_x <= r_inst_d;
          r_inst_m <= r_inst_x;
          r_inst_w <= r_inst_m;
          r_pc_d   <= pc_f;
          r_pc_x   <= r_pc_d;
          r_vld_d  <= 1'b1;
          r_vld_x  <= r_vld_d;
          r_vld_m  <= r_vld_x;
          r_vld_w  <= r_vld_m;
        end
        default: begin
          r_inst_d <= NOP;
          r_inst_x <= NOP;
          r_inst_m <= NOP;
          r_inst_w <= NOP;
          r_pc_d   <= 32'h0000_0000;
          r_pc_x   <= 32'h0000_0000;
          r_vld_d  <= 1'b0;
          r_vld_x  <= 1'b0;
          r_vld_m  <= 1'b0;
          r_vld_w  <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_stall_en),
    .o_cnt (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_flush_en),
    .o_cnt (flush_cnt)
  );

  assign inst_d = r_inst_d;
  assign inst_x = r_inst_x;
  assign inst_m = r_inst_m;
  assign inst_w = r_inst_w;
  assign pc_d   = r_pc_d;
  assign pc_x   = r_pc_x;
  assign vld_d  = r_vld_d;
  assign vld_x  = r_vld_x;
  assign vld_m  = r_vld_m;
  assign vld_w  = r_vld_w;

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed table-driven bench for pipe_ctl plus a long-stall saturation run.
module tb_pipe_ctl;

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] IA = 32'h0050_0093;
  localparam logic [31:0] IB = 32'h00A0_0113;
  localparam logic [31:0] IC = 32'h0002_A283;
  localparam logic [31:0] ID = 32'h0012_8333;
  localparam logic [31:0] IE = 32'h0000_0463;
  localparam logic [31:0] IF = 32'h0030_0193;
  localparam logic [31:0] IG = 32'h0040_0213;
  localparam logic [31:0] IH = 32'h0050_0293;

  typedef struct {
    logic        rst;
    logic        busy;
    logic        br;
    logic [3:0]  hz;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        e_pc_en;
    logic [31:0] e_d, e_x, e_m, e_w;
    logic [31:0] e_pd, e_px;
    logic [3:0]  e_vld;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_f, pc_f;
  logic [3:0]  d_x_m_w;
  logic        br_taken, mem_busy;
  logic [31:0] inst_d, inst_x, inst_m, inst_w, pc_d, pc_x;
  logic        vld_d, vld_x, vld_m, vld_w, pc_en;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pipe_ctl dut (
    .clk(clk), .rst(rst), .inst_f(inst_f), .pc_f(pc_f), .d_x_m_w(d_x_m_w),
    .br_taken(br_taken), .mem_busy(mem_busy),
    .inst_d(inst_d), .inst_x(inst_x), .inst_m(inst_m), .inst_w(inst_w),
    .pc_d(pc_d), .pc_x(pc_x),
    .vld_d(vld_d), .vld_x(vld_x), .vld_m(vld_m), .vld_w(vld_w),
    .pc_en(pc_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic bz, input logic b, input logic [3:0] h,
                              input logic [31:0] i, input logic [31:0] p, input logic pe,
                              input logic [31:0] d, input logic [31:0] x, input logic [31:0] m,
                              input logic [31:0] w, input logic [31:0] pd, input logic [31:0] px,
                              input logic [3:0] v, input logic [15:0] sc, input logic [15:0] fc);
    vec_t t;
    t.rst = r; t.busy = bz; t.br = b; t.hz = h; t.inst = i; t.pc = p; t.e_pc_en = pe;
    t.e_d = d; t.e_x = x; t.e_m = m; t.e_w = w; t.e_pd = pd; t.e_px = px;
    t.e_vld = v; t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction

  task automatic drive(input logic r, input logic bz, input logic b, input logic [3:0] h,
                       input logic [31:0] i, input logic [31:0] p);
    rst = r; mem_busy = bz; br_taken = b; d_x_m_w = h; inst_f = i; pc_f = p;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'b0000, IA, 32'h0);
    //        rst  busy br   hz       inst pc      pc_en d   x   m   w   pc_d    pc_x    vld      stall   flush
    vq.push_back(mk(1'b1,1'b0,1'b0,4'b0000,IA,32'h00,1'b0,N, N, N, N, 32'h00,32'h00,4'b0000,16'd0,16'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,4'b0000,IA,32'h00,1'b0,N, N, N, N, 32'h00,32'h00,4'b0000,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IA,32'h00,1'b1,IA,N, N, N, 32'h00,32'h00,4'b1000,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IB,32'h04,1'b1,IB,IA,N, N, 32'h04,32'h00,4'b1100,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IC,32'h08,1'b1,IC,IB,IA,N, 32'h08,32'h04,4'b1110,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,ID,32'h0C,1'b1,ID,IC,IB,IA,32'h0C,32'h08,4'b1111,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0100,IE,32'h10,1'b0,ID,N, IC,IB,32'h0C,32'h00,4'b1011,16'd1,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IE,32'h10,1'b1,IE,ID,N, IC,32'h10,32'h0C,4'b1101,16'd1,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b1,4'b0100,IF,32'h14,1'b1,N, N, ID,N, 32'h00,32'h00,4'b0010,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IF,32'h20,1'b1,IF,N, N, ID,32'h20,32'h00,4'b1001,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b1011,IG,32'h24,1'b1,IG,IF,N, N, 32'h24,32'h20,4'b1100,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IH,32'h28,1'b1,IH,IG,IF,N, 32'h28,32'h24,4'b1110,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b1,1'b0,4'b0000,IA,32'h2C,1'b0,IH,IG,IF,N, 32'h28,32'h24,4'b1110,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b1,1'b1,4'b0000,IA,32'h2C,1'b0,IH,IG,IF,N, 32'h28,32'h24,4'b1110,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b1,1'b0,4'b0100,IA,32'h2C,1'b0,IH,IG,IF,N, 32'h28,32'h24,4'b1110,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IA,32'h2C,1'b1,IA,IH,IG,IF,32'h2C,32'h28,4'b1111,16'd1,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0100,IB,32'h30,1'b0,IA,N, IH,IG,32'h2C,32'h00,4'b1011,16'd2,16'd1));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0100,IB,32'h30,1'b0,IA,N, N, IH,32'h2C,32'h00,4'b1001,16'd3,16'd1));
    vq.push_back(mk(1'b1,1'b1,1'b0,4'b0100,IB,32'h30,1'b0,N, N, N, N, 32'h00,32'h00,4'b0000,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,4'b0000,IB,32'h30,1'b1,IB,N, N, N, 32'h30,32'h00,4'b1000,16'd0,16'd0));
    vq.push_back(mk(1'b0,1'b0,1'b1,4'b0100,IC,32'h34,1'b1,N, N, N, N, 32'h00,32'h00,4'b0000,16'd0,16'd1));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].busy, vq[i].br, vq[i].hz, vq[i].inst, vq[i].pc);
      #1;
      chk("pc_en", i, {31'd0, pc_en}, {31'd0, vq[i].e_pc_en});
      @(posedge clk);
      #1;
      chk("inst_d", i, inst_d, vq[i].e_d);
      chk("inst_x", i, inst_x, vq[i].e_x);
      chk("inst_m", i, inst_m, vq[i].e_m);
      chk("inst_w", i, inst_w, vq[i].e_w);
      chk("pc_d", i, pc_d, vq[i].e_pd);
      chk("pc_x", i, pc_x, vq[i].e_px);
      chk("vld", i, {28'd0, vld_d, vld_x, vld_m, vld_w}, {28'd0, vq[i].e_vld});
      chk("stall_cnt", i, {16'd0, stall_cnt}, {16'd0, vq[i].e_sc});
      chk("flush_cnt", i, {16'd0, flush_cnt}, {16'd0, vq[i].e_fc});
    end

    // Long load-use stall: counter must reach all ones and then hold.
    drive(1'b1, 1'b0, 1'b0, 4'b0000, IA, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 4'b0100, IA, 32'h0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", 0, {16'd0, stall_cnt}, 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 0, {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_pc_en", 0, {31'd0, pc_en}, 32'd0);
    chk("sat_flush", 0, {16'd0, flush_cnt}, 32'd0);
    chk("sat_vld_x", 0, {31'd0, vld_x}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctl.md
PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 inst_f  in  32  instruction fetched this cycle.
REQ-004 pc_f  in  32  PC of inst_f.
REQ-005 d_x_m_w  in  4  hazard vector from the forwarding unit; [3]=D, [2]=X, [1]=M, [0]=W. Bit [2] set requests a load-use bubble into X.
REQ-006 br_taken  in  1  branch/jump in X resolved taken this cycle.
REQ-007 mem_busy  in  1  data memory not ready; freeze the whole pipeline.
REQ-008 inst_d, inst_x, inst_m, inst_w  out  32 each  stage instruction registers, fed to the forwarding unit.
REQ-009 pc_d, pc_x  out  32 each  stage PC registers.
REQ-010 vld_d, vld_x, vld_m, vld_w  out  1 each  stage holds a real (non-bubble) instruction.
REQ-011 pc_en  out  1  fetch PC may advance this cycle.
REQ-012 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-013 NOP SHALL be 32'h0000_0013 (addi x0,x0,0); every bubble or flush SHALL load NOP with vld=0.
REQ-014 Priority per cycle SHALL be rst > mem_busy > br_taken > d_x_m_w[2] > normal advance.
REQ-015 Normal advance SHALL shift F->D->X->M->W in one cycle (latency 1 per stage); vld_d=1.
REQ-016 mem_busy=1 SHALL hold every stage register, PC register, valid bit and counter; pc_en=0.
REQ-017 br_taken=1 (mem_busy=0) SHALL load NOP into D and X, advance X->M->W, set pc_en=1 (redirect handled by fetch), and increment flush_cnt.
REQ-018 d_x_m_w[2]=1 (no freeze, no branch) SHALL hold D and pc_d, load NOP into X, advance X->M->W, set pc_en=0, and increment stall_cnt.
REQ-019 br_taken and d_x_m_w[2] in the same cycle SHALL act as flush only; stall_cnt SHALL be unchanged.
REQ-020 d_x_m_w bits [3],[1],[0] SHALL be ignored (reserved).
REQ-021 pc_en SHALL be combinational: !mem_busy && (br_taken || !d_x_m_w[2]); pc_en SHALL be 0 while rst=1.
REQ-022 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-023 A stall that persists N consecutive cycles SHALL add N to stall_cnt and insert N bubbles.
REQ-024 Non-valid stages SHALL never raise vld downstream; vld SHALL travel with its instruction.

Reset
REQ-025 While rst=1, at each edge: inst_d..inst_w=NOP, pc_d=pc_x=0, all vld=0, both counters=0.
REQ-026 rst asserted mid-stall or mid-freeze SHALL override; the first cycle after rst deasserts SHALL be normal advance.

Structure
REQ-027 NOP constant, opcode constants and the d_x_m_w bit indices SHALL live in the shared pipeline package.
REQ-028 One sub-module, sat_cnt16 (enable, clear, saturating 16-bit), SHALL be instantiated twice.
REQ-029 Stage registers SHALL be flat in pipe_ctl; no latches; every output SHALL be a register except pc_en.

Verification
REQ-030 Reset: rst=1 for 2 cycles with inst_f=32'h00500093 -> all inst_*=32'h13, vld_*=0, counters 0, pc_en=0.
REQ-031 Streaming: feed 4 distinct instrs (pc 0,4,8,C) with no hazards -> the 1st appears in inst_w on the 4th edge, vld_w=1.
REQ-032 Load-use: lw x5 in X, add x6,x5,x1 in D, d_x_m_w=4'b0100 for 1 cycle -> inst_x=NOP, inst_d/pc_d held, pc_en=0, stall_cnt=1.
REQ-033 Branch: br_taken=1 with d_x_m_w=4'b0100 simultaneously -> inst_d=inst_x=NOP, pc_en=1, flush_cnt=1, stall_cnt=0.
REQ-034 Freeze: mem_busy=1 for 3 cycles during stream -> all registers unchanged, pc_en=0, counters unchanged; resume advances on the 4th edge.
REQ-035 Saturation: preload via 65537 stall cycles -> stall_cnt=16'hFFFF, no wrap.
